// File: rtl/pc_gen_if.sv
// Fetch request handshake between the PC generator and instruction memory.
// master drives the request address; slave accepts it with fetch_ready.
interface pc_gen_if #(
   parameter int XLEN = 32
);
   logic            fetch_valid;
   logic            fetch_ready;
   logic [XLEN-1:0] pc;

   modport master (
      output fetch_valid,
      output pc,
      input  fetch_ready
   );

   modport slave (
      input  fetch_valid,
      input  pc,
      output fetch_ready
   );
endinterface

// File: rtl/pc_gen.sv
// Program counter generator: BOOT/RUN/HALT sequencing, redirect priority.
// Define PC_MISALIGN_CHK_EN to reject misaligned branch/jump targets.
module pc_gen #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
   input  logic            clk,
   input  logic            n_reset,
   pc_gen_if.master        fetch,
   input  logic            stall,
   input  logic            branch,
   input  logic            branch_taken,
   input  logic            jump,
   input  logic [XLEN-1:0] br_pc,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] alu_out,
   input  logic            trap,
   input  logic [XLEN-1:0] trap_vector,
   input  logic            mret,
   input  logic [XLEN-1:0] epc,
   input  logic            wfi,
   input  logic            irq,
   output logic [XLEN-1:0] next_pc,
   output logic            redirect,
   output logic            misaligned
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            redirect_d;
   logic            misaligned_d;

   logic [XLEN-1:0] pc_inc;
   logic [XLEN-1:0] br_tgt;
   logic [XLEN-1:0] raw_tgt;
   logic            take_br;
   logic            ctl_tgt;
   logic            redir_req;
   logic            bad_tgt;
   logic            redir_ok;

   assign pc_inc  = pc_q + XLEN'(4);
   assign br_tgt  = br_pc + imm;
   assign take_br = branch & branch_taken;

   always_comb begin
      raw_tgt = pc_inc;
      ctl_tgt = 1'b0;
      if (trap) begin
         raw_tgt = trap_vector;
      end else if (mret) begin
         raw_tgt = epc;
      end else if (take_br) begin
         raw_tgt = br_tgt;
         ctl_tgt = 1'b1;
      end else if (jump) begin
         raw_tgt = alu_out;
         ctl_tgt = 1'b1;
      end
   end

   assign redir_req = trap | mret | take_br | jump;

`ifdef PC_MISALIGN_CHK_EN
   assign next_pc = raw_tgt;
   assign bad_tgt = ctl_tgt & (|raw_tgt[1:0]);
`else
   // control-flow targets are silently word-aligned
   assign next_pc = ctl_tgt ? {raw_tgt[XLEN-1:2], 2'b00} : raw_tgt;
   assign bad_tgt = 1'b0;
`endif

   assign redir_ok = redir_req & ~bad_tgt;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      redirect_d   = 1'b0;
      misaligned_d = 1'b0;
      unique case (state_q)
         BOOT: begin
            state_d = RUN;
         end
         RUN: begin
            if (redir_ok) begin
               pc_d       = next_pc;
               redirect_d = 1'b1;
            end else if (bad_tgt) begin
               misaligned_d = 1'b1;
            end else if (wfi) begin
               // sleep with pc parked on the instruction after wfi
               pc_d    = pc_inc;
               state_d = HALT;
            end else if (fetch.fetch_ready && !stall) begin
               pc_d = pc_inc;
            end
         end
         HALT: begin
            if (redir_ok) begin
               pc_d       = next_pc;
               redirect_d = 1'b1;
            end else if (bad_tgt) begin
               misaligned_d = 1'b1;
            end
            if (trap || irq) begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = BOOT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q    <= BOOT;
         pc_q       <= RESET_VECTOR;
         redirect   <= 1'b0;
         misaligned <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         redirect   <= redirect_d;
         misaligned <= misaligned_d;
      end
   end

   assign fetch.pc          = pc_q;
   assign fetch.fetch_valid = (state_q == RUN);

endmodule

// File: tb/tb_pc_gen.sv
// Directed testbench for pc_gen.
// Expected values are hand-computed; builds with or without PC_MISALIGN_CHK_EN.
module tb_pc_gen;

   logic        clk;
   logic        n_reset;
   logic        stall;
   logic        branch;
   logic        branch_taken;
   logic        jump;
   logic [31:0] br_pc;
   logic [31:0] imm;
   logic [31:0] alu_out;
   logic        trap;
   logic [31:0] trap_vector;
   logic        mret;
   logic [31:0] epc;
   logic        wfi;
   logic        irq;
   logic [31:0] next_pc;
   logic        redirect;
   logic        misaligned;

   int checks;
   int errors;

   pc_gen_if #(.XLEN(32)) fif ();

   pc_gen #(
      .XLEN         (32),
      .RESET_VECTOR (32'h0)
   ) dut (
      .clk          (clk),
      .n_reset      (n_reset),
      .fetch        (fif),
      .stall        (stall),
      .branch       (branch),
      .branch_taken (branch_taken),
      .jump         (jump),
      .br_pc        (br_pc),
      .imm          (imm),
      .alu_out      (alu_out),
      .trap         (trap),
      .trap_vector  (trap_vector),
      .mret         (mret),
      .epc          (epc),
      .wfi          (wfi),
      .irq          (irq),
      .next_pc      (next_pc),
      .redirect     (redirect),
      .misaligned   (misaligned)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      stall        = 1'b0;
      branch       = 1'b0;
      branch_taken = 1'b0;
      jump         = 1'b0;
      trap         = 1'b0;
      mret         = 1'b0;
      wfi          = 1'b0;
      irq          = 1'b0;
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      n_reset     = 1'b1;
      idle();
      fif.fetch_ready = 1'b1;
      br_pc       = '0;
      imm         = '0;
      alu_out     = '0;
      trap_vector = '0;
      epc         = '0;
      #1 n_reset  = 1'b0;
      #2;
      chk("rst_pc", fif.pc, 32'h0);
      chk("rst_fv", {31'b0, fif.fetch_valid}, 32'h0);
      chk("rst_redir", {31'b0, redirect}, 32'h0);
      chk("rst_mis", {31'b0, misaligned}, 32'h0);

      // inputs ignored while held in reset
      trap        = 1'b1;
      trap_vector = 32'h80;
      jump        = 1'b1;
      alu_out     = 32'h400;
      tick();
      tick();
      chk("rst_ign_pc", fif.pc, 32'h0);
      chk("rst_ign_fv", {31'b0, fif.fetch_valid}, 32'h0);
      idle();
      n_reset = 1'b1;
      #1;
      chk("boot_fv", {31'b0, fif.fetch_valid}, 32'h0);
      chk("boot_pc", fif.pc, 32'h0);
      tick();
      chk("run0_fv", {31'b0, fif.fetch_valid}, 32'h1);
      chk("run0_pc", fif.pc, 32'h0);
      tick();
      chk("run1_pc", fif.pc, 32'h4);
      tick();
      chk("run2_pc", fif.pc, 32'h8);
      chk("seq_npc", next_pc, 32'hC);

      // backpressure
      jump    = 1'b1;
      alu_out = 32'h100;
      tick();
      chk("jmp_pc", fif.pc, 32'h100);
      chk("jmp_redir", {31'b0, redirect}, 32'h1);
      idle();
      fif.fetch_ready = 1'b0;
      tick();
      chk("bp0_pc", fif.pc, 32'h100);
      chk("bp0_redir", {31'b0, redirect}, 32'h0);
      tick();
      chk("bp1_pc", fif.pc, 32'h100);
      tick();
      chk("bp2_pc", fif.pc, 32'h100);
      chk("bp2_fv", {31'b0, fif.fetch_valid}, 32'h1);
      fif.fetch_ready = 1'b1;
      tick();
      chk("bp_rel_pc", fif.pc, 32'h104);

      // taken branch beats jump; negative offset
      br_pc        = 32'h200;
      imm          = 32'hFFFF_FFF0;
      branch       = 1'b1;
      branch_taken = 1'b1;
      jump         = 1'b1;
      alu_out      = 32'h400;
      #1;
      chk("br_npc", next_pc, 32'h1F0);
      tick();
      chk("br_pc", fif.pc, 32'h1F0);
      chk("br_redir", {31'b0, redirect}, 32'h1);
      idle();
      tick();
      chk("br_pc2", fif.pc, 32'h1F4);
      chk("br_redir2", {31'b0, redirect}, 32'h0);

      // not-taken branch falls through
      branch = 1'b1;
      tick();
      chk("nt_pc", fif.pc, 32'h1F8);
      chk("nt_redir", {31'b0, redirect}, 32'h0);
      idle();

      // trap beats mret, ignores stall
      trap        = 1'b1;
      trap_vector = 32'h80;
      mret        = 1'b1;
      epc         = 32'h300;
      stall       = 1'b1;
      tick();
      chk("trap_pc", fif.pc, 32'h80);
      chk("trap_redir", {31'b0, redirect}, 32'h1);
      trap = 1'b0;
      tick();
      chk("mret_pc", fif.pc, 32'h300);
      idle();
      stall = 1'b1;
      tick();
      chk("stall_pc", fif.pc, 32'h300);
      chk("stall_redir", {31'b0, redirect}, 32'h0);
      idle();

      // wrap at top of address space
      jump    = 1'b1;
      alu_out = 32'hFFFF_FFFC;
      tick();
      idle();
      chk("wrap_pre", fif.pc, 32'hFFFF_FFFC);
      tick();
      chk("wrap_pc", fif.pc, 32'h0);

      // wfi / irq
      jump    = 1'b1;
      alu_out = 32'h40;
      tick();
      idle();
      wfi = 1'b1;
      tick();
      chk("wfi_fv", {31'b0, fif.fetch_valid}, 32'h0);
      chk("wfi_pc", fif.pc, 32'h44);
      idle();
      tick();
      chk("halt_fv", {31'b0, fif.fetch_valid}, 32'h0);
      chk("halt_pc", fif.pc, 32'h44);
      irq = 1'b1;
      tick();
      idle();
      chk("irq_fv", {31'b0, fif.fetch_valid}, 32'h1);
      chk("irq_pc", fif.pc, 32'h44);
      tick();
      chk("irq_pc2", fif.pc, 32'h48);

      // trap wakes from HALT
      wfi = 1'b1;
      tick();
      idle();
      chk("wfi2_pc", fif.pc, 32'h4C);
      trap        = 1'b1;
      trap_vector = 32'h80;
      tick();
      idle();
      chk("htrap_pc", fif.pc, 32'h80);
      chk("htrap_fv", {31'b0, fif.fetch_valid}, 32'h1);
      chk("htrap_redir", {31'b0, redirect}, 32'h1);

      // trap together with wfi stays running
      trap        = 1'b1;
      wfi         = 1'b1;
      trap_vector = 32'h90;
      tick();
      idle();
      chk("twfi_pc", fif.pc, 32'h90);
      chk("twfi_fv", {31'b0, fif.fetch_valid}, 32'h1);

      // reset mid-fetch
      fif.fetch_ready = 1'b0;
      #2 n_reset = 1'b0;
      #1;
      chk("mrst_pc", fif.pc, 32'h0);
      chk("mrst_fv", {31'b0, fif.fetch_valid}, 32'h0);
      tick();
      n_reset = 1'b1;
      fif.fetch_ready = 1'b1;
      tick();
      chk("mrst_run_pc", fif.pc, 32'h0);
      chk("mrst_run_fv", {31'b0, fif.fetch_valid}, 32'h1);
      tick();
      chk("mrst_pc4", fif.pc, 32'h4);

      // misaligned jump target
      jump    = 1'b1;
      alu_out = 32'h102;
      tick();
      idle();
`ifdef PC_MISALIGN_CHK_EN
      chk("mis_pc", fif.pc, 32'h4);
      chk("mis_flag", {31'b0, misaligned}, 32'h1);
      chk("mis_redir", {31'b0, redirect}, 32'h0);
      tick();
      chk("mis_flag2", {31'b0, misaligned}, 32'h0);
      chk("mis_pc2", fif.pc, 32'h8);
`else
      chk("mis_pc", fif.pc, 32'h100);
      chk("mis_flag", {31'b0, misaligned}, 32'h0);
      chk("mis_redir", {31'b0, redirect}, 32'h1);
      tick();
      chk("mis_flag2", {31'b0, misaligned}, 32'h0);
      chk("mis_pc2", fif.pc, 32'h104);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
